// File: rtl/display_scan_ctrl.sv
// Multiplexed hex display scanner: walks one digit per slot with a guard gap,
// shows a tear-free snapshot of value/dp_mask, and optionally hides leading zeros.
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIV        = 100000,
  parameter int unsigned GUARD      = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      lz_blank,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [NUM_DIGITS-1:0]     digit_select,
  output logic [3:0]                segment_data,
  output logic                      dp_n,
  output logic                      frame_start
);

  localparam int unsigned PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [PSC_W-1:0]                psc, psc_nxt;
  logic [IDX_W-1:0]                idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]      snap, snap_nxt;
  logic [NUM_DIGITS-1:0]           snap_dp, snap_dp_nxt;
  logic                            first_frame;
  logic                            load_c;
  logic [NUM_DIGITS-1:0]           zero_from;
  logic                            zero_acc;
  logic                            blank_c;
  logic                            lit_c;

  // Scan position and snapshot as they will be after this edge
  always_comb begin
    psc_nxt     = psc;
    idx_nxt     = idx;
    snap_nxt    = snap;
    snap_dp_nxt = snap_dp;
    load_c      = 1'b0;
    if (enable) begin
      load_c = first_frame ||
               ((idx == IDX_W'(NUM_DIGITS - 1)) && (psc == PSC_W'(DIV - 1)));
      if (psc == PSC_W'(DIV - 1)) begin
        psc_nxt = '0;
        idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        psc_nxt = psc + PSC_W'(1);
      end
      if (load_c) begin
        snap_nxt    = value;
        snap_dp_nxt = dp_mask;
      end
    end
  end

  // zero_from[i]: nibbles i..top of the upcoming snapshot are all zero
  always_comb begin
    zero_acc  = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc && (snap_nxt[i] == 4'h0);
      zero_from[i] = zero_acc;
    end
  end

  always_comb begin
    blank_c = lz_blank && (idx_nxt != '0) && zero_from[idx_nxt];
    lit_c   = enable && (psc_nxt >= PSC_W'(GUARD)) && !blank_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc          <= '0;
      idx          <= '0;
      snap         <= '0;
      snap_dp      <= '0;
      first_frame  <= 1'b1;
      digit_select <= '1;
      segment_data <= 4'h0;
      dp_n         <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      psc         <= psc_nxt;
      idx         <= idx_nxt;
      snap        <= snap_nxt;
      snap_dp     <= snap_dp_nxt;
      frame_start <= load_c;
      if (load_c) begin
        first_frame <= 1'b0;
      end
      if (lit_c) begin
        digit_select <= ~(NUM_DIGITS'(1) << idx_nxt);
        segment_data <= snap_nxt[idx_nxt];
        dp_n         <= ~snap_dp_nxt[idx_nxt];
      end else begin
        digit_select <= '1;
        segment_data <= 4'h0;
        dp_n         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a frame-position model.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          lz_blank = 1'b0;
  logic [15:0]   value = 16'h0;
  logic [3:0]    dp_mask = 4'h0;
  logic [3:0]    digit_select;
  logic [3:0]    segment_data;
  logic          dp_n;
  logic          frame_start;

  display_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .lz_blank     (lz_blank),
    .value        (value),
    .dp_mask      (dp_mask),
    .digit_select (digit_select),
    .segment_data (segment_data),
    .dp_n         (dp_n),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  // Model: absolute position within the frame plus the captured frame
  int          pos;
  bit          first;
  logic [15:0] snap_v;
  logic [3:0]  snap_dp;
  logic [3:0]  exp_ds;
  logic [3:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fs;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int  d, p;
    bit  load, blank;
    if (reset) begin
      pos = 0; first = 1'b1; snap_v = '0; snap_dp = '0;
      exp_ds = 4'hF; exp_seg = 4'h0; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      load = enable && (first || pos == FRAME - 1);
      if (enable) pos = (pos + 1) % FRAME;
      if (load) begin
        snap_v = value; snap_dp = dp_mask; first = 1'b0;
      end
      exp_fs = load;
      d = pos / DIV;
      p = pos % DIV;
      blank = lz_blank && d != 0 && ((snap_v >> (4 * d)) == 16'h0);
      if (enable && p >= GUARD && !blank) begin
        exp_ds  = 4'hF ^ 4'(1 << d);
        exp_seg = 4'((snap_v >> (4 * d)) & 16'hF);
        exp_dp  = ~snap_dp[d];
      end else begin
        exp_ds = 4'hF; exp_seg = 4'h0; exp_dp = 1'b1;
      end
    end
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("digit_select", 32'(digit_select), 32'(exp_ds));
    chk("segment_data", 32'(segment_data), 32'(exp_seg));
    chk("dp_n",         32'(dp_n),         32'(exp_dp));
    chk("frame_start",  32'(frame_start),  32'(exp_fs));
  endtask

  task automatic run_to(input int target);
    int guard_cnt = 0;
    while (pos != target && guard_cnt < 200) begin
      cycle();
      guard_cnt++;
    end
    if (pos != target) chk("run_to_timeout", 32'(pos), 32'(target));
  endtask

  initial begin
    logic [15:0] mask;
    pos = 0; first = 1'b1; snap_v = '0; snap_dp = '0;
    exp_ds = 4'hF; exp_seg = 4'h0; exp_dp = 1'b1; exp_fs = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_ds", 32'(digit_select), 32'h0000000F);
      chk("rst_seg", 32'(segment_data), 32'h0);
      chk("rst_dp", 32'(dp_n), 32'h1);
      chk("rst_fs", 32'(frame_start), 32'h0);
    end

    reset = 1'b0; enable = 1'b1; value = 16'h1234; dp_mask = 4'b0100;
    cycle();
    chk("first_fs", 32'(frame_start), 32'h1);
    chk("first_guard_ds", 32'(digit_select), 32'hF);
    cycle();
    chk("d0_ds", 32'(digit_select), 32'hE);
    chk("d0_seg", 32'(segment_data), 32'h4);
    chk("d0_dp", 32'(dp_n), 32'h1);
    chk("d0_fs", 32'(frame_start), 32'h0);
    run_to(10);
    value = 16'hABCD;
    cycle();
    chk("d1_ds", 32'(digit_select), 32'hD);
    chk("d1_seg_old", 32'(segment_data), 32'h3);
    run_to(18);
    chk("d2_ds", 32'(digit_select), 32'hB);
    chk("d2_seg", 32'(segment_data), 32'h2);
    chk("d2_dp", 32'(dp_n), 32'h0);

    // Pause at psc=5 of digit 2
    run_to(21);
    enable = 1'b0;
    cycle();
    chk("pause_ds", 32'(digit_select), 32'hF);
    for (int i = 0; i < 9; i++) cycle();
    enable = 1'b1;
    cycle();
    chk("resume_ds", 32'(digit_select), 32'hB);
    chk("resume_fs", 32'(frame_start), 32'h0);
    cycle();
    cycle();
    chk("next_slot_guard", 32'(digit_select), 32'hF);

    // New frame picks up ABCD
    run_to(0);
    chk("abcd_fs", 32'(frame_start), 32'h1);
    value = 16'h0040; lz_blank = 1'b1; dp_mask = 4'b0000;
    run_to(2);
    chk("abcd_d0_seg", 32'(segment_data), 32'hD);

    // Leading-zero suppression on 0040
    run_to(0);
    run_to(2);
    chk("lz_d0_ds", 32'(digit_select), 32'hE);
    chk("lz_d0_seg", 32'(segment_data), 32'h0);
    run_to(10);
    chk("lz_d1_seg", 32'(segment_data), 32'h4);
    run_to(18);
    chk("lz_d2_ds", 32'(digit_select), 32'hF);
    run_to(26);
    chk("lz_d3_ds", 32'(digit_select), 32'hF);
    value = 16'h0000;
    run_to(0);
    run_to(10);
    chk("zero_d1_ds", 32'(digit_select), 32'hF);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 4))
          0: mask = 16'hFFFF;
          1: mask = 16'h0FFF;
          2: mask = 16'h00FF;
          3: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        value   = 16'($urandom) & mask;
        dp_mask = 4'($urandom);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
